bbox_overlay: RTL and testbench
===============================

# bbox_overlay

Parametrised bounding-box overlay for the recognition video path. It draws up to NUM_BOX rectangular outlines onto the pixel stream, each with its own colour and a configurable line thickness. It generates its own pixel coordinates from the sync/DE timing and double-buffers box coordinates so they only change at frame boundaries. It sits between the detection/position logic and the HDMI/VGA output stage, replacing the fixed four-box green overlay.

## Interface
- NUM_BOX, 8: number of independent boxes (1..16).
- CW, 12: coordinate width in bits.
- LINE_W, 2: border thickness in pixels (1..15).
- DW, 24: pixel width, RGB888.
- pixelclk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- i_rgb  in  DW  input pixel.
- i_hsync, i_vsync, i_de  in  1 each  input timing; vsync and hsync are active-high.
- box_valid  in  NUM_BOX  per-box enable.
- box_x0, box_x1, box_y0, box_y1  in  NUM_BOX*CW each  box k at bits [k*CW +: CW]; inclusive corners.
- box_color  in  NUM_BOX*DW  outline colour per box.
- cfg_update  in  1  one-cycle pulse; captures all box_* inputs into staging.
- o_rgb  out  DW  output pixel.
- o_hsync, o_vsync, o_de  out  1 each  timing delayed to match o_rgb.
- o_hit  out  NUM_BOX  per-box border hit for the pixel on o_rgb (debug/statistics).

## Operation
- Coordinates:
  - x counts DE-high pixels within a line and is 0 on the first active pixel.
  - x resets to 0 on DE falling edge.
  - y increments on each DE falling edge and resets to 0 on the vsync rising edge.
  - Both counters saturate at 2^CW-1; there is no wrap.
- Configuration (three banks):
  - cfg_update copies box_* into the staging bank and sets pending.
  - On the vsync rising edge with pending set, staging is copied to the active bank and pending clears.
  - If cfg_update coincides with the vsync rising edge, the live box_* values load directly into both staging and active, and pending ends 0.
  - A cfg_update mid-frame never alters the frame currently being drawn.
- Hit test for box k, using the active bank and (CW+1)-bit arithmetic:
  - The box must be valid, with x0<=x1 and y0<=y1.
  - The pixel must lie inside the box: x0<=x<=x1 and y0<=y<=y1.
  - The pixel must be on the border: x<x0+LINE_W, or x+LINE_W>x1, or y<y0+LINE_W, or y+LINE_W>y1.
  - Boxes with x1<x0 or y1<y0 never hit.
  - A box narrower than 2*LINE_W renders solid.
- Output pixel:
  - If any box hits, o_rgb is the box_color of the lowest-index hitting box.
  - Otherwise o_rgb is the delayed i_rgb.
  - During DE low, o_rgb is the delayed i_rgb unconditionally, and o_hit is 0.

## Timing
- Latency is 2 cycles for o_rgb, o_hsync, o_vsync, o_de and o_hit together; all outputs stay mutually aligned.
- Pipeline stages:
  - Stage 1 registers the pixel, the sync signals and the per-box hit vector.
  - Stage 2 registers the priority mux output.
- Counters update on the cycle after the DE/vsync edge is detected. Edge detection uses a one-cycle registered copy of i_de and i_vsync.
- Reset values:
  - All outputs 0.
  - x and y are 0; pending is 0.
  - Staging and active banks are all-zero, so box_valid is 0 and nothing is drawn.
- Reset mid-frame: drawing stops immediately. The first frame after reset release draws no boxes until a cfg_update followed by a vsync rising edge.
- The active bank is stable for the whole frame. Changes take effect from the first active pixel after the vsync rising edge that follows loading.

## Structure
- Package overlay_pkg holds:
  - the default CW and DW;
  - named colour constants (GREEN 24'h00ff00, RED 24'hff0000, and others);
  - the function used for the border comparison width (CW+1).
- Sub-module bbox_hit: a combinational per-box test (x, y, corners, valid, LINE_W → hit). It is instantiated NUM_BOX times through generate and registered in stage 1 of the parent.
- The parent owns the counters, edge detection, the staging/active/pending banks, the priority encoder and the delay pipeline.

## Test plan
- Box 0 at (10,10)-(20,15), LINE_W=1, GREEN, cfg_update, then vsync:
  - next frame pixels (10,12), (20,12), (15,10) and (15,15) output 00ff00;
  - pixel (15,12) passes i_rgb;
  - every output is delayed exactly 2 cycles from its input.
- Boxes 0 (RED) and 3 (GREEN) overlap at (12,12) → RED output and o_hit=4'b1001. Clearing box_valid[0] via cfg_update and vsync → GREEN from the next frame.
- cfg_update issued mid-frame with new coordinates → the current frame keeps the old box; the new box appears only after the following vsync rising edge.
- cfg_update on the same cycle as the vsync rising edge → the new box is drawn in that frame, and pending reads 0 afterwards.
- Degenerate boxes:
  - x1=5, x0=9 → never drawn;
  - LINE_W=3 with box (0,0)-(3,3) → all 16 pixels coloured, with no underflow at x1<LINE_W.
- Assert reset mid-frame, then release → outputs are 0 during reset, and no box is drawn until a fresh cfg_update and vsync.

Source files
------------

// File: rtl/overlay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | overlay_pkg: shared defaults, colour constants and width helpers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package overlay_pkg;

  localparam int C_DEFAULT_CW = 12;
  localparam int C_DEFAULT_DW = 24;

  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] WHITE   = 24'hffffff;
  localparam logic [23:0] RED     = 24'hff0000;
  localparam logic [23:0] GREEN   = 24'h00ff00;
  localparam logic [23:0] BLUE    = 24'h0000ff;
  localparam logic [23:0] YELLOW  = 24'hffff00;
  localparam logic [23:0] CYAN    = 24'h00ffff;
  localparam logic [23:0] MAGENTA = 24'hff00ff;

  // One spare bit so corner+LINE_W never wraps at the top of the range.
  function automatic int border_width(input int cw);
    return cw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_hit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bbox_hit: combinational border test of one pixel against one box.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bbox_hit
  import overlay_pkg::*;
#(
  parameter int CW     = C_DEFAULT_CW,
  parameter int LINE_W = 2
) (
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [CW-1:0] i_x0,
  input  logic [CW-1:0] i_x1,
  input  logic [CW-1:0] i_y0,
  input  logic [CW-1:0] i_y1,
  input  logic          i_valid,
  output logic          o_hit
);

  localparam int BW = border_width(CW);
  localparam logic [BW-1:0] C_LW = BW'(LINE_W);

  logic [BW-1:0] w_x, w_y, w_x0, w_x1, w_y0, w_y1;
  logic          w_ordered, w_inside, w_border;

  assign w_x  = BW'(i_x);
  assign w_y  = BW'(i_y);
  assign w_x0 = BW'(i_x0);
  assign w_x1 = BW'(i_x1);
  assign w_y0 = BW'(i_y0);
  assign w_y1 = BW'(i_y1);

  assign w_ordered = (w_x0 <= w_x1) && (w_y0 <= w_y1);
  assign w_inside  = (w_x >= w_x0) && (w_x <= w_x1) && (w_y >= w_y0) && (w_y <= w_y1);
  // Adding LINE_W to the pixel side avoids subtracting from small corners.
  assign w_border  = (w_x < w_x0 + C_LW) || (w_x + C_LW > w_x1) ||
                     (w_y < w_y0 + C_LW) || (w_y + C_LW > w_y1);

  assign o_hit = i_valid && w_ordered && w_inside && w_border;

endmodule
`default_nettype wire

// File: rtl/bbox_overlay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bbox_overlay: draws up to NUM_BOX coloured outlines on a pixel stream|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bbox_overlay
  import overlay_pkg::*;
#(
  parameter int NUM_BOX = 8,
  parameter int CW      = C_DEFAULT_CW,
  parameter int LINE_W  = 2,
  parameter int DW      = C_DEFAULT_DW
) (
  input  logic                  pixelclk,
  input  logic                  reset,
  input  logic [DW-1:0]         i_rgb,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic [NUM_BOX-1:0]    box_valid,
  input  logic [NUM_BOX*CW-1:0] box_x0,
  input  logic [NUM_BOX*CW-1:0] box_x1,
  input  logic [NUM_BOX*CW-1:0] box_y0,
  input  logic [NUM_BOX*CW-1:0] box_y1,
  input  logic [NUM_BOX*DW-1:0] box_color,
  input  logic                  cfg_update,
  output logic [DW-1:0]         o_rgb,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic [NUM_BOX-1:0]    o_hit
);

  logic                  r_de_d, r_vs_d;
  logic                  w_vs_rise, w_de_fall;
  logic [CW-1:0]         r_x, r_y;

  logic                  r_pending;
  logic [NUM_BOX-1:0]    r_stg_valid, r_act_valid;
  logic [NUM_BOX*CW-1:0] r_stg_x0, r_stg_x1, r_stg_y0, r_stg_y1;
  logic [NUM_BOX*CW-1:0] r_act_x0, r_act_x1, r_act_y0, r_act_y1;
  logic [NUM_BOX*DW-1:0] r_stg_color, r_act_color;

  logic [NUM_BOX-1:0]    w_hit;
  logic [DW-1:0]         r1_rgb;
  logic                  r1_hsync, r1_vsync, r1_de;
  logic [NUM_BOX-1:0]    r1_hit;
  logic [DW-1:0]         w_mux_rgb;

  assign w_vs_rise = i_vsync && !r_vs_d;
  assign w_de_fall = r_de_d && !i_de;

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_de_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_de_d <= i_de;
      r_vs_d <= i_vsync;
      if (w_de_fall)
        r_x <= '0;
      else if (i_de && r_x != '1)
        r_x <= r_x + CW'(1);
      if (w_vs_rise)
        r_y <= '0;
      else if (w_de_fall && r_y != '1)
        r_y <= r_y + CW'(1);
    end
  end

  // A simultaneous cfg_update and frame start bypasses staging entirely.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_stg_valid <= '0;
      r_stg_x0    <= '0;
      r_stg_x1    <= '0;
      r_stg_y0    <= '0;
      r_stg_y1    <= '0;
      r_stg_color <= '0;
      r_act_valid <= '0;
      r_act_x0    <= '0;
      r_act_x1    <= '0;
      r_act_y0    <= '0;
      r_act_y1    <= '0;
      r_act_color <= '0;
    end else if (cfg_update && w_vs_rise) begin
      r_stg_valid <= box_valid;
      r_stg_x0    <= box_x0;
      r_stg_x1    <= box_x1;
      r_stg_y0    <= box_y0;
      r_stg_y1    <= box_y1;
      r_stg_color <= box_color;
      r_act_valid <= box_valid;
      r_act_x0    <= box_x0;
      r_act_x1    <= box_x1;
      r_act_y0    <= box_y0;
      r_act_y1    <= box_y1;
      r_act_color <= box_color;
      r_pending   <= 1'b0;
    end else begin
      if (w_vs_rise && r_pending) begin
        r_act_valid <= r_stg_valid;
        r_act_x0    <= r_stg_x0;
        r_act_x1    <= r_stg_x1;
        r_act_y0    <= r_stg_y0;
        r_act_y1    <= r_stg_y1;
        r_act_color <= r_stg_color;
        r_pending   <= 1'b0;
      end
      if (cfg_update) begin
        r_stg_valid <= box_valid;
        r_stg_x0    <= box_x0;
        r_stg_x1    <= box_x1;
        r_stg_y0    <= box_y0;
        r_stg_y1    <= box_y1;
        r_stg_color <= box_color;
        r_pending   <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
    bbox_hit #(
      .CW     (CW),
      .LINE_W (LINE_W)
    ) u_hit (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_x0    (r_act_x0[k*CW +: CW]),
      .i_x1    (r_act_x1[k*CW +: CW]),
      .i_y0    (r_act_y0[k*CW +: CW]),
      .i_y1    (r_act_y1[k*CW +: CW]),
      .i_valid (r_act_valid[k]),
      .o_hit   (w_hit[k])
    );
  end

  // Scan downwards so the lowest-index hitting box has the final say.
  always_comb begin
    w_mux_rgb = r1_rgb;
    for (int k = NUM_BOX - 1; k >= 0; k--) begin
      if (r1_hit[k])
        w_mux_rgb = r_act_color[k*DW +: DW];
    end
  end

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r1_rgb   <= '0;
      r1_hsync <= 1'b0;
      r1_vsync <= 1'b0;
      r1_de    <= 1'b0;
      r1_hit   <= '0;
      o_rgb    <= '0;
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_de     <= 1'b0;
      o_hit    <= '0;
    end else begin
      r1_rgb   <= i_rgb;
      r1_hsync <= i_hsync;
      r1_vsync <= i_vsync;
      r1_de    <= i_de;
      r1_hit   <= i_de ? w_hit : '0;
      o_rgb    <= w_mux_rgb;
      o_hsync  <= r1_hsync;
      o_vsync  <= r1_vsync;
      o_de     <= r1_de;
      o_hit    <= r1_hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bbox_overlay.sv
`default_nettype none
// Self-checking bench for bbox_overlay: two instances (LINE_W 1 and 3) share
// one stimulus stream and are scored against a frame-level reference model.
module tb_bbox_overlay;
  import overlay_pkg::*;

  localparam int NB = 4;
  localparam int CW = 12;
  localparam int DW = 24;
  localparam int W  = 24;
  localparam int H  = 20;

  logic pixelclk = 1'b0;
  logic reset    = 1'b1;
  always #5 pixelclk = ~pixelclk;

  logic [DW-1:0]    i_rgb = '0;
  logic             i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0, cfg_update = 1'b0;
  logic [NB-1:0]    box_valid;
  logic [NB*CW-1:0] box_x0, box_x1, box_y0, box_y1;
  logic [NB*DW-1:0] box_color;

  logic [DW-1:0] o_rgb1, o_rgb3;
  logic          o_hs1, o_vs1, o_de1, o_hs3, o_vs3, o_de3;
  logic [NB-1:0] o_hit1, o_hit3;

  bbox_overlay #(.NUM_BOX(NB), .CW(CW), .LINE_W(1), .DW(DW)) u_dut_lw1 (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .box_valid(box_valid), .box_x0(box_x0),
    .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1), .box_color(box_color),
    .cfg_update(cfg_update), .o_rgb(o_rgb1), .o_hsync(o_hs1), .o_vsync(o_vs1),
    .o_de(o_de1), .o_hit(o_hit1));

  bbox_overlay #(.NUM_BOX(NB), .CW(CW), .LINE_W(3), .DW(DW)) u_dut_lw3 (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .box_valid(box_valid), .box_x0(box_x0),
    .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1), .box_color(box_color),
    .cfg_update(cfg_update), .o_rgb(o_rgb3), .o_hsync(o_hs3), .o_vsync(o_vs3),
    .o_de(o_de3), .o_hit(o_hit3));

  typedef struct {
    bit            v;
    int            x0, x1, y0, y1;
    logic [DW-1:0] col;
  } box_t;

  typedef struct {
    logic [DW-1:0] rgb1, rgb3, in_rgb;
    logic [NB-1:0] hit1, hit3;
    logic          hs, vs, de;
    int            x, y;
  } exp_t;

  typedef struct {
    int            tag, lw, x, y;
    bit            pass;
    logic [DW-1:0] rgb;
    logic [NB-1:0] hit;
  } probe_t;

  box_t   live[NB], stg[NB], act[NB];
  bit     pend, prev_vs;
  exp_t   q[$];
  probe_t probes[$];

  logic [DW-1:0] fb1[H][W], fb3[H][W], in_fb[H][W];
  logic [NB-1:0] hb1[H][W], hb3[H][W];

  int checks = 0;
  int errors = 0;

  always_comb begin
    box_valid = '0;
    box_x0 = '0; box_x1 = '0; box_y0 = '0; box_y1 = '0; box_color = '0;
    for (int k = 0; k < NB; k++) begin
      box_valid[k]          = live[k].v;
      box_x0[k*CW +: CW]    = CW'(live[k].x0);
      box_x1[k*CW +: CW]    = CW'(live[k].x1);
      box_y0[k*CW +: CW]    = CW'(live[k].y0);
      box_y1[k*CW +: CW]    = CW'(live[k].y1);
      box_color[k*DW +: DW] = live[k].col;
    end
  end

  function automatic box_t mk_box(input bit v, input int x0, input int y0,
                                  input int x1, input int y1, input logic [DW-1:0] col);
    box_t b;
    b.v = v; b.x0 = x0; b.y0 = y0; b.x1 = x1; b.y1 = y1; b.col = col;
    return b;
  endfunction

  function automatic void add_probe(input int tag, input int lw, input int x, input int y,
                                    input bit pass, input logic [DW-1:0] rgb,
                                    input logic [NB-1:0] hit);
    probe_t p;
    p.tag = tag; p.lw = lw; p.x = x; p.y = y; p.pass = pass; p.rgb = rgb; p.hit = hit;
    probes.push_back(p);
  endfunction

  // Reference: a pixel is on box k's outline if it is inside the box and
  // within lw pixels of any edge; the lowest-numbered such box wins.
  function automatic void model_pixel(input int lw, input int x, input int y,
                                      input logic [DW-1:0] rgb,
                                      output logic [DW-1:0] orgb, output logic [NB-1:0] ohit);
    bit found = 0;
    orgb = rgb;
    ohit = '0;
    for (int k = 0; k < NB; k++) begin
      box_t b = act[k];
      if (b.v && b.x0 <= b.x1 && b.y0 <= b.y1 &&
          x >= b.x0 && x <= b.x1 && y >= b.y0 && y <= b.y1 &&
          (x - b.x0 < lw || b.x1 - x < lw || y - b.y0 < lw || b.y1 - y < lw)) begin
        ohit[k] = 1'b1;
        if (!found) begin
          orgb  = b.col;
          found = 1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int x, input int y,
                       input logic [DW-1:0] a_rgb, input logic a_hs, input logic a_vs,
                       input logic a_de, input logic [NB-1:0] a_hit,
                       input logic [DW-1:0] e_rgb, input logic e_hs, input logic e_vs,
                       input logic e_de, input logic [NB-1:0] e_hit);
    checks++;
    if ({a_rgb, a_hs, a_vs, a_de, a_hit} !== {e_rgb, e_hs, e_vs, e_de, e_hit}) begin
      errors++;
      $display("FAIL %s (%0d,%0d): got rgb=%h hs=%b vs=%b de=%b hit=%b, expected rgb=%h hs=%b vs=%b de=%b hit=%b",
               name, x, y, a_rgb, a_hs, a_vs, a_de, a_hit, e_rgb, e_hs, e_vs, e_de, e_hit);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_lw1"}, -1, -1, o_rgb1, o_hs1, o_vs1, o_de1, o_hit1, '0, 1'b0, 1'b0, 1'b0, '0);
    check({name, "_lw3"}, -1, -1, o_rgb3, o_hs3, o_vs3, o_de3, o_hit3, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < NB; k++) begin
      stg[k] = mk_box(0, 0, 0, 0, 0, '0);
      act[k] = mk_box(0, 0, 0, 0, 0, '0);
    end
    pend    = 0;
    prev_vs = 0;
  endtask

  // One pixel clock: score the entry issued two cycles ago, then drive.
  task automatic step(input logic de, input logic hs, input logic vs, input logic cfg,
                      input int x, input int y);
    exp_t e;
    bit   vs_rise;
    @(posedge pixelclk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("pipe_lw1", e.x, e.y, o_rgb1, o_hs1, o_vs1, o_de1, o_hit1,
            e.rgb1, e.hs, e.vs, e.de, e.hit1);
      check("pipe_lw3", e.x, e.y, o_rgb3, o_hs3, o_vs3, o_de3, o_hit3,
            e.rgb3, e.hs, e.vs, e.de, e.hit3);
      if (e.de && e.x >= 0 && e.x < W && e.y >= 0 && e.y < H) begin
        fb1[e.y][e.x]   = o_rgb1;
        fb3[e.y][e.x]   = o_rgb3;
        hb1[e.y][e.x]   = o_hit1;
        hb3[e.y][e.x]   = o_hit3;
        in_fb[e.y][e.x] = e.in_rgb;
      end
    end
    i_rgb      = DW'($urandom());
    i_de       = de;
    i_hsync    = hs;
    i_vsync    = vs;
    cfg_update = cfg;
    e.in_rgb = i_rgb; e.hs = hs; e.vs = vs; e.de = de; e.x = x; e.y = y;
    if (de) begin
      model_pixel(1, x, y, i_rgb, e.rgb1, e.hit1);
      model_pixel(3, x, y, i_rgb, e.rgb3, e.hit3);
    end else begin
      e.rgb1 = i_rgb; e.rgb3 = i_rgb; e.hit1 = '0; e.hit3 = '0;
    end
    q.push_back(e);
    vs_rise = vs && !prev_vs;
    prev_vs = vs;
    if (cfg && vs_rise) begin
      for (int k = 0; k < NB; k++) begin stg[k] = live[k]; act[k] = live[k]; end
      pend = 0;
    end else begin
      if (vs_rise && pend) begin
        for (int k = 0; k < NB; k++) act[k] = stg[k];
        pend = 0;
      end
      if (cfg) begin
        for (int k = 0; k < NB; k++) stg[k] = live[k];
        pend = 1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge pixelclk);
    #1;
    reset      = 1'b1;
    cfg_update = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (n) begin
      @(posedge pixelclk);
      #1;
      check_zero("reset_hold");
    end
    reset = 1'b0;
    q.delete();
    clear_model();
  endtask

  task automatic idle(input int n, input int cfg_at);
    for (int i = 0; i < n; i++) step(0, 0, 0, i == cfg_at, -1, -1);
  endtask

  task automatic run_frame(input int cfg_line, input int cfg_px, input bit cfg_vs,
                           input int rst_line);
    step(0, 0, 1, cfg_vs, -1, -1);
    step(0, 0, 1, 0, -1, -1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, -1, -1);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == rst_line && x == 5) do_reset(3);
        step(1, 0, 0, (y == cfg_line) && (x == cfg_px), x, y);
      end
      for (int b = 0; b < 6; b++) step(0, (b == 1) || (b == 2), 0, 0, -1, -1);
    end
  endtask

  task automatic check_probes(input int tag);
    foreach (probes[i]) begin
      if (probes[i].tag == tag) begin
        probe_t p = probes[i];
        logic [DW-1:0] a_rgb, e_rgb;
        logic [NB-1:0] a_hit;
        a_rgb = (p.lw == 1) ? fb1[p.y][p.x] : fb3[p.y][p.x];
        a_hit = (p.lw == 1) ? hb1[p.y][p.x] : hb3[p.y][p.x];
        e_rgb = p.pass ? in_fb[p.y][p.x] : p.rgb;
        checks++;
        if (a_rgb !== e_rgb || a_hit !== p.hit) begin
          errors++;
          $display("FAIL probe tag=%0d lw=%0d (%0d,%0d): got rgb=%h hit=%b, expected rgb=%h hit=%b",
                   tag, p.lw, p.x, p.y, a_rgb, a_hit, e_rgb, p.hit);
        end
      end
    end
  endtask

  initial begin
    // tag, LINE_W, x, y, passthrough, colour, hit vector
    add_probe(1, 1, 10, 12, 0, GREEN, 4'b0001);
    add_probe(1, 1, 20, 12, 0, GREEN, 4'b0001);
    add_probe(1, 1, 15, 10, 0, GREEN, 4'b0001);
    add_probe(1, 1, 15, 15, 0, GREEN, 4'b0001);
    add_probe(1, 1, 15, 12, 1, '0,    4'b0000);
    add_probe(1, 1,  0,  0, 0, RED,   4'b0010);
    add_probe(1, 1,  1,  1, 1, '0,    4'b0000);
    add_probe(1, 1,  7,  5, 1, '0,    4'b0000);
    add_probe(1, 3,  0,  0, 0, RED,   4'b0010);
    add_probe(1, 3,  3,  3, 0, RED,   4'b0010);
    add_probe(1, 3,  1,  2, 0, RED,   4'b0010);
    add_probe(1, 3,  2,  1, 0, RED,   4'b0010);
    add_probe(1, 3, 15, 13, 0, GREEN, 4'b0001);
    add_probe(1, 3,  7,  5, 1, '0,    4'b0000);
    add_probe(2, 1, 12, 12, 0, RED,   4'b1001);
    add_probe(2, 3, 12, 12, 0, RED,   4'b1001);
    add_probe(3, 1, 12, 12, 0, GREEN, 4'b1000);
    add_probe(3, 3, 12, 12, 0, GREEN, 4'b1000);
    add_probe(4, 1,  2,  3, 1, '0,    4'b0000);
    add_probe(4, 3,  2,  3, 1, '0,    4'b0000);
    add_probe(4, 1, 12, 12, 0, GREEN, 4'b1000);
    add_probe(5, 1,  2,  3, 0, YELLOW, 4'b0010);
    add_probe(5, 3,  2,  3, 0, YELLOW, 4'b0010);
    add_probe(5, 1, 12, 12, 0, GREEN, 4'b1000);
    add_probe(6, 1,  9,  0, 0, WHITE, 4'b0100);
    add_probe(6, 1, 12, 12, 0, GREEN, 4'b1000);
    add_probe(7, 3,  9,  0, 0, WHITE, 4'b0100);
    add_probe(8, 1,  9,  0, 0, WHITE, 4'b0100);
    add_probe(8, 1, 12, 12, 1, '0,    4'b0000);
    add_probe(9, 1,  9,  0, 1, '0,    4'b0000);
    add_probe(9, 3, 12, 12, 1, '0,    4'b0000);
    add_probe(10, 1, 12, 12, 0, GREEN, 4'b1000);
    add_probe(10, 3,  9,  0, 0, WHITE, 4'b0100);

    for (int k = 0; k < NB; k++) live[k] = mk_box(0, 0, 0, 0, 0, '0);
    clear_model();

    repeat (3) @(posedge pixelclk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;

    // Box geometry, thin/thick borders, a tiny box and an inverted box.
    live[0] = mk_box(1, 10, 10, 20, 15, GREEN);
    live[1] = mk_box(1,  0,  0,  3,  3, RED);
    live[2] = mk_box(1,  9,  0,  5, 17, BLUE);
    live[3] = mk_box(0,  0,  0,  0,  0, '0);
    idle(4, 1);
    run_frame(-1, -1, 0, -1);
    check_probes(1);

    // Overlap priority, then drop the higher-priority box.
    live[0] = mk_box(1, 12, 12, 18, 18, RED);
    live[1] = mk_box(0,  0,  0,  0,  0, '0);
    live[2] = mk_box(0,  0,  0,  0,  0, '0);
    live[3] = mk_box(1,  5,  5, 12, 12, GREEN);
    idle(4, 1);
    run_frame(-1, -1, 0, -1);
    check_probes(2);
    live[0].v = 0;
    idle(4, 1);
    run_frame(-1, -1, 0, -1);
    check_probes(3);

    // Mid-frame update only shows up from the next frame.
    live[1] = mk_box(1, 2, 2, 6, 6, YELLOW);
    run_frame(1, 0, 0, -1);
    check_probes(4);
    run_frame(-1, -1, 0, -1);
    check_probes(5);

    // Update coinciding with the frame start is drawn immediately.
    live[2] = mk_box(1, 8, 0, 10, 2, WHITE);
    run_frame(-1, -1, 1, -1);
    check_probes(6);
    run_frame(-1, -1, 0, -1);
    check_probes(7);

    // Reset mid-frame wipes the banks until a fresh update.
    run_frame(-1, -1, 0, 5);
    check_probes(8);
    run_frame(-1, -1, 0, -1);
    check_probes(9);
    idle(4, 1);
    run_frame(-1, -1, 0, -1);
    check_probes(10);

    // Random box sets and update timing against the reference model.
    for (int f = 0; f < 5; f++) begin
      int mode;
      for (int k = 0; k < NB; k++)
        live[k] = mk_box($urandom_range(0, 3) != 0,
                         $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                         $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                         DW'($urandom()));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        idle(3, 1);
        run_frame(-1, -1, 0, -1);
      end else if (mode == 1) begin
        run_frame($urandom_range(0, H - 1), $urandom_range(0, W - 1), 0, -1);
      end else begin
        run_frame(-1, -1, 1, -1);
      end
    end
    run_frame(-1, -1, 0, -1);
    idle(4, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
